// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier (SIZE x SIZE -> 2*SIZE), one multiplier bit per RUN cycle.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.

module custom_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[W];
endmodule

module shift_add_mult #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   multiplicand,
  input  logic [SIZE-1:0]   multiplier,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product
);
  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [SIZE-1:0] mcand, mq, addend, sum;
  // Upper partial product; its extra top bit is always zero after the shift, so it is not stored.
  logic [SIZE-1:0] p_hi;
  logic [CW-1:0]   cnt;
  logic            cout;

  assign addend = mq[0] ? mcand : '0;

  custom_adder #(.W(SIZE)) u_add (
    .a   (p_hi),
    .b   (addend),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

`ifdef EARLY_TERM_EN
  logic              rest_zero;
  logic [2*SIZE-1:0] early_prod;

  // Bits mq[cnt-1:0] still await processing; a shift of all-ones by SIZE yields zero, so the mask saturates.
  assign rest_zero  = (mq & ~({SIZE{1'b1}} << cnt)) == '0;
  assign early_prod = {p_hi, mq} >> cnt;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mq      <= '0;
      p_hi    <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= multiplicand;
            mq    <= multiplier;
            p_hi  <= '0;
            cnt   <= CW'(SIZE);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
`ifdef EARLY_TERM_EN
          if (rest_zero) begin
            product <= early_prod;
            cnt     <= '0;
            state   <= DONE;
          end else
`endif
          begin
            p_hi <= {cout, sum[SIZE-1:1]};
            mq   <= {sum[0], mq[SIZE-1:1]};
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              product <= {cout, sum, mq[SIZE-1:1]};
              state   <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed table-driven bench for shift_add_mult (SIZE=32); latency expectations follow EARLY_TERM_EN.

module tb_shift_add_mult;
  localparam int SIZE = 32;
`ifdef EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  localparam int INJ    = ET ? 2 : 10;
  localparam int RST_AT = ET ? 3 : 5;
  localparam int PER    = ET ? 6 : 33;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [SIZE-1:0]   mc, mp;
  logic              busy, done;
  logic [2*SIZE-1:0] product;

  int errs = 0;
  int checks = 0;
  logic [63:0] last_p;

  always #5 clk = ~clk;

  shift_add_mult #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .multiplicand(mc),
    .multiplier  (mp),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int          lat_et;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one multiply, scramble operands after acceptance, and check latency, busy, hold and result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p,
                        input int l, input string tag);
    int n, bc;
    bit held_ok;
    @(negedge clk); start = 1'b1; mc = a; mp = b;
    @(negedge clk); start = 1'b0; mc = ~a; mp = ~b;
    n = 0; bc = 0; held_ok = 1'b1;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (product !== last_p) held_ok = 1'b0;
      @(negedge clk); n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(l));
    chk({tag, " busy_cycles"}, 64'(bc), 64'(l));
    chk({tag, " product_held"}, 64'(held_ok), 64'd1);
    chk({tag, " product"}, product, p);
    chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
    last_p = p;
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n, ndone, last, bad;

    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 4};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 32};
    vecs[2] = '{32'h0000_1234,  32'd0,          64'd0,                   1};
    vecs[3] = '{32'd6,          32'd1,          64'd6,                   2};
    vecs[4] = '{32'd5,          32'h8000_0000,  64'h0000_0002_8000_0000, 32};
    vecs[5] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 32};
    vecs[6] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE, 3};
    vecs[7] = '{32'd0,          32'hFFFF_FFFF,  64'd0,                   32};
    vecs[8] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF, 32};
    vecs[9] = '{32'd7,          32'd9,          64'd63,                  5};

    rst = 1'b1; start = 1'b0; mc = '0; mp = '0; last_p = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", product, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, ET ? vecs[i].lat_et : 32, $sformatf("vec%0d", i));

    // Start pulsed mid-run must be ignored; start in DONE chains a new operation.
    @(negedge clk); start = 1'b1; mc = 32'd7; mp = 32'd9;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk); n++;
      if (n == INJ) begin start = 1'b1; mc = 32'd2; mp = 32'd2; end
      else if (n == INJ + 1) start = 1'b0;
    end
    chk("ignore_start latency", 64'(n), 64'(ET ? 5 : 32));
    chk("ignore_start product", product, 64'd63);
    start = 1'b1; mc = 32'd2; mp = 32'd2;
    @(negedge clk); start = 1'b0;
    chk("chain busy", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("chain latency", 64'(n), 64'(ET ? 3 : 32));
    chk("chain product", product, 64'd4);
    @(negedge clk);

    // Reset mid-run aborts without a done pulse.
    start = 1'b1; mc = 32'd10; mp = 32'd10;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < RST_AT; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort product", product, 64'd0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (done) ndone++; end
    chk("abort no_done", 64'(ndone), 64'd0);

    // Start held high: periodic done pulses, busy low only in DONE.
    start = 1'b1; mc = 32'd12; mp = 32'd12;
    ndone = 0; last = -1; bad = 0;
    for (int c = 1; c <= 4 * PER; c++) begin
      @(negedge clk);
      if (busy == done) bad++;
      if (done) begin
        if (last >= 0) chk("b2b period", 64'(c - last), 64'(PER));
        chk("b2b product", product, 64'd144);
        last = c;
        ndone++;
      end
    end
    chk("b2b done_count", 64'(ndone), 64'd4);
    chk("b2b busy_vs_done", 64'(bad), 64'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter SIZE, default 32, SHALL set the operand width; the product SHALL be 2*SIZE bits wide.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a new multiply; it is sampled only in IDLE or DONE.
REQ-005 multiplicand  input  SIZE  SHALL be the unsigned operand A, captured at the accepting edge.
REQ-006 multiplier  input  SIZE  SHALL be the unsigned operand B, captured at the accepting edge.
REQ-007 busy  output  1  SHALL be high exactly while in RUN.
REQ-008 done  output  1  SHALL be a one-cycle pulse, high exactly while in DONE.
REQ-009 product  output  2*SIZE  SHALL be the registered result A*B, valid from done and held until the next accepted start.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-011 In IDLE or DONE with start=1, edge E0 SHALL load mcand=A, P_hi=0 (SIZE+1 bits), mq=B and cnt=SIZE, then enter RUN.
REQ-012 Each RUN edge SHALL compute {cout,sum} = P_hi[SIZE-1:0] + (mq[0] ? mcand : 0) with Cin=0, using one custom_adder instance of width SIZE.
REQ-013 Each RUN edge SHALL then shift {cout,sum,mq} right by one into {P_hi,mq} and decrement cnt.
REQ-014 The edge at which cnt goes from 1 to 0 SHALL enter DONE and register product = {P_hi[SIZE-1:0],mq} after the shift (the SIZE-th edge after E0).
REQ-015 DONE SHALL last one cycle and then return to IDLE, unless start=1, in which case it SHALL enter RUN per REQ-011.
REQ-016 start SHALL be ignored while in RUN; the operation in flight SHALL be unaffected.
REQ-017 The product SHALL be exact modulo 2^(2*SIZE); no overflow flag SHALL be provided.
REQ-018 Changes on the operand inputs after E0 SHALL NOT affect the result.
REQ-019 product SHALL hold its value through RUN, and SHALL change only when entering DONE or on reset.

Reset
REQ-020 rst=1 at any edge SHALL force IDLE, busy=0, done=0, product=0, cnt=0, P_hi=0, mq=0 and mcand=0.
REQ-021 rst SHALL take priority over start and over an operation in RUN; an aborted operation SHALL produce no done.

Configuration
REQ-022 Macro EARLY_TERM_EN: when defined, at each RUN edge where the unprocessed multiplier bits mq[cnt-1:0] are all zero, the block SHALL skip the add.
REQ-023 In that case, the block SHALL register product = ({P_hi,mq} >> cnt)[2*SIZE-1:0] and enter DONE at that edge.
REQ-024 Without EARLY_TERM_EN, the latency SHALL always be SIZE RUN edges, regardless of the operand values.

Verification (SIZE=32)
REQ-025 A=3, B=5, pulse start -> busy for 32 cycles, then done for 1 cycle with product=64'h0000_0000_0000_000F (early termination disabled).
REQ-026 A=B=32'hFFFF_FFFF -> done after 32 RUN edges, product=64'hFFFF_FFFE_0000_0001; mid-run operand changes have no effect.
REQ-027 A=7, B=9, started, then start pulsed with A=2, B=2 at RUN cycle 10 -> the second request is ignored and product=63; a start in the DONE cycle with A=2, B=2 yields 4 after a further 32 edges.
REQ-028 A=10, B=10, rst asserted at RUN cycle 5 -> next cycle busy=0, done=0, product=0, and no done pulse follows.
REQ-029 EARLY_TERM_EN defined: B=0 -> done after edge 1 with product=0; A=6, B=1 -> done after edge 2 with product=6; A=5, B=32'h8000_0000 -> full 32 edges with product=64'h0000_0002_8000_0000.
REQ-030 Back-to-back: start held high continuously with fixed A=12, B=12 -> a done pulse every 33 cycles with product=144, and busy low only in DONE cycles.
